mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS controller FSM. Sequences fetch/decode/execute/memory/writeback.
- Drives write strobes for PC, IR, register file and data memory.
- Drives the datapath configuration selects: immediate-extender mode (ExtOp), ALU source/operation, register destination, write-back source and next-PC operation.
- Sits between the IR opcode/funct fields and the datapath. Also counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]; stable from DECODE onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, valid in EXE
- PCWr  output  1  PC write enable
- IRWr  output  1  IR write enable
- RegWr  output  1  register-file write enable
- MemWr  output  1  data-memory write enable
- ExtOp  output  1  1 = sign extend, 0 = zero extend
- ALUSrc  output  1  1 = extended immediate, 0 = rt
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 lui (imm<<16)
- RegDst  output  1  1 = rd, 0 = rt
- MemtoReg  output  1  1 = memory data, 0 = ALU result
- NPCOp  output  2  00 PC+4, 01 branch, 10 jump
- state  output  3  current state (debug)
- retired  output  CNT_W  retired-instruction count
- halted  output  1  illegal-instruction halt (see Optional Feature)

Behaviour:
- Supported instructions (opcode/funct):
  - R-type 000000 with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
  - Anything else is illegal, including opcode 000000 with any other funct.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=5. Values 6 and 7 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE -> FETCH for j or an illegal instruction; otherwise -> EXE.
  - EXE -> FETCH for beq; -> MEM for lw/sw; -> WB for all others.
  - MEM -> FETCH for sw; -> WB for lw.
  - WB -> FETCH.
- Strobes (combinational from state and decode):
  - FETCH: PCWr=1, IRWr=1, NPCOp=00.
  - DECODE, j: PCWr=1, NPCOp=10.
  - EXE, beq: ALUOp=sub, ALUSrc=0, NPCOp=01, PCWr=zero.
  - MEM, sw: MemWr=1.
  - WB: RegWr=1.
  - Every strobe not listed is 0.
- ExtOp: 1 for addiu, lw, sw, beq; 0 for ori, lui, R-type and j. Forced 0 in FETCH. In all other states it is held from decode.
- ALUSrc: 1 for addiu, ori, lui, lw, sw; 0 otherwise. Held constant from DECODE to the end of the instruction.
- ALUOp:
  - R-type: from funct (addu and subu as listed above).
  - addiu, lw, sw: add. ori: or. lui: lui. beq: sub.
- RegDst=1 only for R-type. MemtoReg=1 only for lw.
- retired: increments by 1 (mod 2^CNT_W) on each transition into FETCH from DECODE (j only), EXE, MEM or WB. An illegal instruction does not count.
- CPI: j=2, beq=3, R-type/imm=4, sw=4, lw=5.
- Reset:
  - While rst=1 the combinational strobes PCWr, IRWr, RegWr and MemWr are forced 0.
  - On the edge: state<=FETCH, retired<=0, halted<=0.
  - Reset mid-instruction abandons the instruction with no write.
  - The first fetch happens in the first cycle after rst deasserts.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction in DECODE goes to HALT.
  - HALT: all strobes 0, halted=1. HALT is left only by rst.
- Undefined:
  - An illegal instruction in DECODE returns to FETCH as a NOP.
  - halted is tied to 0 and the HALT state is never entered.

Test Plan:
- Reset hold: rst=1 for 3 cycles -> PCWr=IRWr=RegWr=MemWr=0. After release, cycle 1: state=0, PCWr=1, IRWr=1. retired=0.
- ori then addiu:
  - opcode=001101 -> ExtOp=0 in DECODE/EXE/WB, ALUOp=011, ALUSrc=1, RegDst=0, RegWr=1 only in WB (4th cycle). retired=1.
  - opcode=001001 -> ExtOp=1, ALUOp=000. retired=2.
- lw/sw: lw -> states 0,1,2,3,4, MemtoReg=1, RegWr in WB only. sw -> states 0,1,2,3, MemWr=1 in MEM only, RegWr never asserted.
- beq: zero=1 in EXE -> PCWr=1, NPCOp=01, ExtOp=1. zero=0 -> PCWr=0. Either case returns to FETCH after 3 cycles, retired+1.
- j and illegal: j -> PCWr=1, NPCOp=10 in DECODE, 2-cycle instruction. opcode=111111:
  - with ILLEGAL_TRAP_EN -> state=5, halted=1, no strobes for 10 cycles, retired unchanged.
  - without -> back to FETCH, retired unchanged.
- Reset mid-instruction and counter wrap:
  - rst=1 during MEM of sw -> MemWr=0 that cycle, state=0 next.
  - With CNT_W=4, after 16 retirements -> retired=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: sequences FETCH..WB, drives datapath selects
// and write strobes, counts retired instructions. Option: ILLEGAL_TRAP_EN.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic             ExtOp,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic [1:0]       NPCOp,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    logic w_rtype, w_addu, w_subu, w_and, w_or, w_slt, w_rlegal;
    logic w_addiu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_legal;
    logic w_ext, w_src, w_regdst, w_m2r;
    logic [2:0] w_aluop;

    assign w_rtype  = (opcode == 6'b000000);
    assign w_addu   = w_rtype && (funct == 6'b100001);
    assign w_subu   = w_rtype && (funct == 6'b100011);
    assign w_and    = w_rtype && (funct == 6'b100100);
    assign w_or     = w_rtype && (funct == 6'b100101);
    assign w_slt    = w_rtype && (funct == 6'b101010);
    assign w_rlegal = w_addu | w_subu | w_and | w_or | w_slt;

    assign w_addiu = (opcode == 6'b001001);
    assign w_ori   = (opcode == 6'b001101);
    assign w_lui   = (opcode == 6'b001111);
    assign w_lw    = (opcode == 6'b100011);
    assign w_sw    = (opcode == 6'b101011);
    assign w_beq   = (opcode == 6'b000100);
    assign w_j     = (opcode == 6'b000010);
    assign w_legal = w_rlegal | w_addiu | w_ori | w_lui
                   | w_lw | w_sw | w_beq | w_j;

    assign w_ext    = w_addiu | w_lw | w_sw | w_beq;
    assign w_src    = w_addiu | w_ori | w_lui | w_lw | w_sw;
    assign w_regdst = w_rlegal;
    assign w_m2r    = w_lw;

    always_comb begin
        w_aluop = 3'b000;
        case (1'b1)
            w_subu, w_beq: w_aluop = 3'b001;
            w_and:         w_aluop = 3'b010;
            w_or, w_ori:   w_aluop = 3'b011;
            w_slt:         w_aluop = 3'b100;
            w_lui:         w_aluop = 3'b101;
            default:       w_aluop = 3'b000;
        endcase
    end

    // Retirement is tied to the instruction's final transition back to FETCH.
    always_comb begin
        w_next   = S_FETCH;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
                end else if (w_j) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                if (w_beq) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (w_sw) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT:  w_next = S_HALT;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Selects follow the decoded opcode from DECODE to the end of the instruction.
    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        ExtOp    = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 3'b000;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        NPCOp    = 2'b00;
        if (r_state == S_DECODE || r_state == S_EXE ||
            r_state == S_MEM || r_state == S_WB) begin
            ExtOp    = w_ext;
            ALUSrc   = w_src;
            ALUOp    = w_aluop;
            RegDst   = w_regdst;
            MemtoReg = w_m2r;
        end
        case (r_state)
            S_FETCH: begin
                PCWr = 1'b1;
                IRWr = 1'b1;
            end
            S_DECODE: begin
                if (w_j) begin
                    PCWr  = 1'b1;
                    NPCOp = 2'b10;
                end
            end
            S_EXE: begin
                if (w_beq) begin
                    PCWr  = zero;
                    NPCOp = 2'b01;
                end
            end
            S_MEM:   MemWr = w_sw;
            S_WB:    RegWr = 1'b1;
            default: ;
        endcase
        if (rst) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

    assign state   = r_state;
    assign retired = r_retired;
`ifdef ILLEGAL_TRAP_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
